game_flow_fsm: RTL and testbench
================================

Name: game_flow_fsm

Overview:
Parametrised game-progression controller, successor to the fixed 3-bit level/world FSM.
- Sequences title, play, pause, death, level-up, world-up, game-over and win screens.
- Tracks level, world and lives, and drives player disable, object-reset select and audio cue selection.
- Sits between ps2interface (button pulses), PlayerObject (player_dead), Scrolls (level_complete), Audio (seq_end) and the Scrolls/Obstacles/Screens/Reset_Mux blocks.

Parameters:
NUM_WORLDS, 4, number of worlds; the last one ends in WIN
LEVELS_PER_WORLD, 3, levels per world
START_LIVES, 3, lives at game start; also the width of lives_led
LVL_W, 3, width of level output
WORLD_W, 3, width of world output
LIVES_W, 3, width of lives output
HOLD_CYCLES, 100000000, auto-advance timeout for DIED/LEVEL_UP/WORLD_UP; 0 disables the timeout
RESET_PULSE, 4, cycles reset_select is held in ARM (must be at least 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_btn  in  1  start key level; rising edge detected internally
continue_btn  in  1  continue key level; rising edge detected internally
pause_btn  in  1  pause key level; rising edge detected internally
player_dead  in  1  one-cycle pulse from PlayerObject
level_complete  in  1  one-cycle pulse from Scrolls
audio_seq_end  in  1  one-cycle pulse from Audio at end of a cue
level  out  LVL_W  level index within the current world, 0..LEVELS_PER_WORLD-1
world  out  WORLD_W  world index, 0..NUM_WORLDS-1
screen  out  3  0 title, 1 play, 2 lose, 3 win, 4 level+, 5 world+, 6 pause, 7 died
lives  out  LIVES_W  remaining lives
lives_led  out  START_LIVES  thermometer code, (1<<lives)-1
player_disable  out  1  high except in PLAY
reset_select  out  1  drives Reset_Mux; high only in ARM
audio_select  out  3  cue code
audio_enable  out  1  audio run enable

Behaviour:
- All outputs are registered. An input event changes the outputs on the first clk edge after the event is sampled (1-cycle latency).
- Edge detectors: one flop per button, reset to 0. A button held high through reset does not produce an edge.
- Reset state: IDLE, level 0, world 0, lives START_LIVES, lives_led all ones, screen 0, player_disable 1, reset_select 0, audio_select 0, audio_enable 0. Timer and ARM counter reset to 0.
- States:
  - IDLE: screen 0, silent. start edge -> ARM; level←0, world←0, lives←START_LIVES.
  - ARM: reset_select 1 for exactly RESET_PULSE cycles, player_disable 1, screen unchanged from the previous state. Then -> PLAY.
  - PLAY: player_disable 0, screen 1, audio_select 1, audio_enable 1 continuously (music loops; audio_seq_end ignored).
    - player_dead has priority over level_complete when both arrive in the same cycle; pause has lowest priority.
    - player_dead: lives←lives-1; if lives was 1 -> GAME_OVER, else -> DIED.
    - level_complete:
      - last level of the last world -> WIN.
      - last level of any other world -> WORLD_UP; world+1, level←0.
      - otherwise -> LEVEL_UP; level+1.
    - pause edge -> PAUSE.
  - PAUSE: screen 6, audio_enable 0, player_disable 1. pause or continue edge -> PLAY (no ARM). player_dead and level_complete are ignored.
  - DIED / LEVEL_UP / WORLD_UP: screen 7/4/5, audio_select 2/3/4.
    - Timer clears on entry. Exit on continue edge, or when timer reaches HOLD_CYCLES-1 (if HOLD_CYCLES≠0); exit goes to ARM.
  - GAME_OVER / WIN: screen 2/3, audio_select 5/6. Exit on start or continue edge -> IDLE; counters keep their values until the next start.
- Audio in non-PLAY cue states: audio_enable goes to 1 on entry and drops to 0 the cycle after audio_seq_end. It stays 0 until the state changes.
- Counters saturate and never wrap: lives never goes below 0, level and world never exceed their maximums.
- An asynchronous rst in any state returns every register to its reset values immediately.

Test Plan:
- Reset, then start edge → ARM with reset_select=1 for 4 cycles, then PLAY with screen=1, player_disable=0, lives=3, lives_led=3'b111.
- In PLAY, level_complete ×2 with continue each time → LEVEL_UP (level 1), then LEVEL_UP (level 2); a third level_complete → WORLD_UP with world=1, level=0, screen=5.
- player_dead ×3, continuing after each → DIED (lives 2, led 011), DIED (lives 1, led 001), then GAME_OVER with lives=0, screen=2, audio_select=5; continue → IDLE.
- player_dead and level_complete in the same cycle with lives=3 → DIED, lives=2, level unchanged.
- Pause edge in PLAY → screen 6, audio_enable 0, player_dead ignored; second pause edge → PLAY directly, no reset_select pulse.
- With HOLD_CYCLES=10: enter LEVEL_UP with no continue → ARM after exactly 10 cycles. audio_seq_end at cycle 3 → audio_enable low from cycle 4. rst asserted mid-ARM → IDLE outputs immediately.

Source files
------------

// File: rtl/game_flow_fsm.sv
// Game progression controller: title/play/pause/death/level/world/end screens,
// level/world/lives bookkeeping, player disable, object reset and audio cue select.
//
//  state      | meaning
//  IDLE       | title screen, silent, waiting for start
//  ARM        | reset_select pulse to Reset_Mux, screen held from previous state
//  PLAY       | player active, music looping
//  PAUSE      | frozen, music muted, pause/continue resumes
//  DIED       | life lost, cue plays, continue or timeout re-arms
//  LEVEL_UP   | level advanced, cue plays, continue or timeout re-arms
//  WORLD_UP   | world advanced, cue plays, continue or timeout re-arms
//  GAME_OVER  | no lives left, start/continue returns to title
//  WIN        | last level of last world cleared, start/continue returns to title
module game_flow_fsm #(
   parameter int NUM_WORLDS       = 4,
   parameter int LEVELS_PER_WORLD = 3,
   parameter int START_LIVES      = 3,
   parameter int LVL_W            = 3,
   parameter int WORLD_W          = 3,
   parameter int LIVES_W          = 3,
   parameter int HOLD_CYCLES      = 100000000,
   parameter int RESET_PULSE      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_btn,
   input  logic                   continue_btn,
   input  logic                   pause_btn,
   input  logic                   player_dead,
   input  logic                   level_complete,
   input  logic                   audio_seq_end,
   output logic [LVL_W-1:0]       level,
   output logic [WORLD_W-1:0]     world,
   output logic [2:0]             screen,
   output logic [LIVES_W-1:0]     lives,
   output logic [START_LIVES-1:0] lives_led,
   output logic                   player_disable,
   output logic                   reset_select,
   output logic [2:0]             audio_select,
   output logic                   audio_enable
);

   typedef enum logic [3:0] {
      IDLE, ARM, PLAY, PAUSE, DIED, LEVEL_UP, WORLD_UP, GAME_OVER, WIN
   } state_t;

   localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int ARM_W = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
   localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [ARM_W-1:0]   ARM_LOAD   = ARM_W'(RESET_PULSE - 1);
   localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(LEVELS_PER_WORLD - 1);
   localparam logic [WORLD_W-1:0] WORLD_LAST = WORLD_W'(NUM_WORLDS - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
   localparam bit                 HOLD_EN    = (HOLD_CYCLES != 0);

   state_t                 state, stateNext;
   logic                   edgeArm, startPrev, continuePrev, pausePrev;
   logic                   startEdge, continueEdge, pauseEdge;
   logic                   cueState, cueNext;
   logic [ARM_W-1:0]       armCnt, armCntNext;
   logic [TMR_W-1:0]       holdTmr, holdTmrNext;
   logic [LVL_W-1:0]       levelNext;
   logic [WORLD_W-1:0]     worldNext;
   logic [LIVES_W-1:0]     livesNext;
   logic [START_LIVES-1:0] livesLedNext;
   logic [2:0]             screenNext, audioSelectNext;
   logic                   audioEnableNext;

   // edgeArm blocks edges on the first cycle after reset so a key held through reset is not seen
   assign startEdge    = edgeArm & start_btn    & ~startPrev;
   assign continueEdge = edgeArm & continue_btn & ~continuePrev;
   assign pauseEdge    = edgeArm & pause_btn    & ~pausePrev;

   assign cueState = (state == DIED) || (state == LEVEL_UP) || (state == WORLD_UP) ||
                     (state == GAME_OVER) || (state == WIN);
   assign cueNext  = (stateNext == DIED) || (stateNext == LEVEL_UP) || (stateNext == WORLD_UP) ||
                     (stateNext == GAME_OVER) || (stateNext == WIN);

   // state, counters, edge flops and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         edgeArm        <= 1'b0;
         startPrev      <= 1'b0;
         continuePrev   <= 1'b0;
         pausePrev      <= 1'b0;
         armCnt         <= '0;
         holdTmr        <= '0;
         level          <= '0;
         world          <= '0;
         lives          <= LIVES_INIT;
         lives_led      <= '1;
         screen         <= 3'd0;
         player_disable <= 1'b1;
         reset_select   <= 1'b0;
         audio_select   <= 3'd0;
         audio_enable   <= 1'b0;
      end else begin
         state          <= stateNext;
         edgeArm        <= 1'b1;
         startPrev      <= start_btn;
         continuePrev   <= continue_btn;
         pausePrev      <= pause_btn;
         armCnt         <= armCntNext;
         holdTmr        <= holdTmrNext;
         level          <= levelNext;
         world          <= worldNext;
         lives          <= livesNext;
         lives_led      <= livesLedNext;
         screen         <= screenNext;
         player_disable <= (stateNext != PLAY);
         reset_select   <= (stateNext == ARM);
         audio_select   <= audioSelectNext;
         audio_enable   <= audioEnableNext;
      end
   end

   // next state and counter updates
   always_comb begin
      stateNext   = state;
      armCntNext  = armCnt;
      holdTmrNext = holdTmr;
      levelNext   = level;
      worldNext   = world;
      livesNext   = lives;
      case (state)
         IDLE: begin
            if (startEdge) begin
               stateNext = ARM;
               levelNext = '0;
               worldNext = '0;
               livesNext = LIVES_INIT;
            end
         end
         ARM: begin
            if (armCnt == '0) stateNext = PLAY;
            else              armCntNext = armCnt - ARM_W'(1);
         end
         PLAY: begin
            if (player_dead) begin
               if (lives > LIVES_W'(1)) begin
                  livesNext = lives - LIVES_W'(1);
                  stateNext = DIED;
               end else begin
                  livesNext = '0;
                  stateNext = GAME_OVER;
               end
            end else if (level_complete) begin
               if (level >= LVL_LAST) begin
                  if (world >= WORLD_LAST) begin
                     stateNext = WIN;
                  end else begin
                     worldNext = world + WORLD_W'(1);
                     levelNext = '0;
                     stateNext = WORLD_UP;
                  end
               end else begin
                  levelNext = level + LVL_W'(1);
                  stateNext = LEVEL_UP;
               end
            end else if (pauseEdge) begin
               stateNext = PAUSE;
            end
         end
         PAUSE: begin
            if (pauseEdge || continueEdge) stateNext = PLAY;
         end
         DIED, LEVEL_UP, WORLD_UP: begin
            if (continueEdge)                          stateNext = ARM;
            else if (HOLD_EN && (holdTmr == TMR_LAST)) stateNext = ARM;
            else if (HOLD_EN)                          holdTmrNext = holdTmr + TMR_W'(1);
         end
         GAME_OVER, WIN: begin
            if (startEdge || continueEdge) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (stateNext != state) begin
         holdTmrNext = '0;
         if (stateNext == ARM) armCntNext = ARM_LOAD;
      end
   end

   // screen, audio cue and lives display for the state being entered
   always_comb begin
      screenNext      = screen;
      audioSelectNext = 3'd0;
      case (stateNext)
         IDLE:      screenNext = 3'd0;
         ARM:       screenNext = screen;
         PLAY:      begin screenNext = 3'd1; audioSelectNext = 3'd1; end
         PAUSE:     begin screenNext = 3'd6; audioSelectNext = 3'd1; end
         DIED:      begin screenNext = 3'd7; audioSelectNext = 3'd2; end
         LEVEL_UP:  begin screenNext = 3'd4; audioSelectNext = 3'd3; end
         WORLD_UP:  begin screenNext = 3'd5; audioSelectNext = 3'd4; end
         GAME_OVER: begin screenNext = 3'd2; audioSelectNext = 3'd5; end
         WIN:       begin screenNext = 3'd3; audioSelectNext = 3'd6; end
         default:   screenNext = 3'd0;
      endcase
      if (stateNext != state) audioEnableNext = (stateNext == PLAY) || cueNext;
      else                    audioEnableNext = audio_enable & ~(cueState & audio_seq_end);
      for (int i = 0; i < START_LIVES; i++) begin
         livesLedNext[i] = (livesNext > LIVES_W'(i));
      end
   end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm: directed walk through the game flow with
// literal expectations, then randomized stimulus against a behavioural model.
module tb_game_flow_fsm;
   localparam int NW = 4, LPW = 3, SL = 3, HOLD = 10, RP = 4;

   logic       clk = 1'b0, rst = 1'b1;
   logic       start_btn = 1'b0, continue_btn = 1'b0, pause_btn = 1'b0;
   logic       player_dead = 1'b0, level_complete = 1'b0, audio_seq_end = 1'b0;
   logic [2:0] level, world, screen, lives, audio_select;
   logic [2:0] lives_led;
   logic       player_disable, reset_select, audio_enable;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   game_flow_fsm #(
      .NUM_WORLDS(NW), .LEVELS_PER_WORLD(LPW), .START_LIVES(SL),
      .LVL_W(3), .WORLD_W(3), .LIVES_W(3), .HOLD_CYCLES(HOLD), .RESET_PULSE(RP)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .continue_btn(continue_btn),
      .pause_btn(pause_btn), .player_dead(player_dead), .level_complete(level_complete),
      .audio_seq_end(audio_seq_end), .level(level), .world(world), .screen(screen),
      .lives(lives), .lives_led(lives_led), .player_disable(player_disable),
      .reset_select(reset_select), .audio_select(audio_select), .audio_enable(audio_enable)
   );

   // phases: 0 title, 1 arm, 2 play, 3 pause, 4 died, 5 level+, 6 world+, 7 game over, 8 win
   int phaseScreen[9] = '{0, -1, 1, 6, 7, 4, 5, 2, 3};
   int phaseCue[9]    = '{0, 0, 1, 1, 2, 3, 4, 5, 6};

   int mPhase, mArmLeft, mHoldAge, mLevel, mWorld, mLives, mScreen, nxt;
   bit mAudioOn, mReady, mPrevS, mPrevC, mPrevP, sE, cE, pE;

   // behavioural model of the game rules
   always @(posedge clk or posedge rst) begin : model
      if (rst) begin
         mPhase = 0; mArmLeft = 0; mHoldAge = 0; mLevel = 0; mWorld = 0; mLives = SL;
         mScreen = 0; mAudioOn = 0; mReady = 0; mPrevS = 0; mPrevC = 0; mPrevP = 0;
      end else begin
         sE = mReady && start_btn && !mPrevS;
         cE = mReady && continue_btn && !mPrevC;
         pE = mReady && pause_btn && !mPrevP;
         nxt = mPhase;
         case (mPhase)
            0: if (sE) begin nxt = 1; mLevel = 0; mWorld = 0; mLives = SL; end
            1: begin mArmLeft--; if (mArmLeft == 0) nxt = 2; end
            2: begin
               if (player_dead) begin
                  if (mLives > 0) mLives--;
                  nxt = (mLives == 0) ? 7 : 4;
               end else if (level_complete) begin
                  if (mLevel == LPW - 1) begin
                     if (mWorld == NW - 1) nxt = 8;
                     else begin mWorld++; mLevel = 0; nxt = 6; end
                  end else begin
                     mLevel++; nxt = 5;
                  end
               end else if (pE) nxt = 3;
            end
            3: if (pE || cE) nxt = 2;
            4, 5, 6: begin
               mHoldAge++;
               if (cE || (HOLD != 0 && mHoldAge >= HOLD)) nxt = 1;
            end
            default: if (sE || cE) nxt = 0;
         endcase
         if (nxt != mPhase) begin
            if (nxt == 1) mArmLeft = RP;
            mHoldAge = 0;
            mAudioOn = (nxt == 2) || (nxt >= 4);
            if (phaseScreen[nxt] >= 0) mScreen = phaseScreen[nxt];
            mPhase = nxt;
         end else if (mPhase >= 4 && audio_seq_end) begin
            mAudioOn = 0;
         end
         mPrevS = start_btn; mPrevC = continue_btn; mPrevP = pause_btn;
         mReady = 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compareAll();
      chk("screen", 32'(screen), mScreen);
      chk("level", 32'(level), mLevel);
      chk("world", 32'(world), mWorld);
      chk("lives", 32'(lives), mLives);
      chk("lives_led", 32'(lives_led), (1 << mLives) - 1);
      chk("player_disable", 32'(player_disable), 32'(mPhase != 2));
      chk("reset_select", 32'(reset_select), 32'(mPhase == 1));
      chk("audio_select", 32'(audio_select), phaseCue[mPhase]);
      chk("audio_enable", 32'(audio_enable), 32'(mAudioOn));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      compareAll();
   endtask

   // 0 start, 1 continue, 2 pause, 3 dead, 4 level complete, 5 audio end
   task automatic sigPulse(input int which);
      case (which)
         0: start_btn = 1; 1: continue_btn = 1; 2: pause_btn = 1;
         3: player_dead = 1; 4: level_complete = 1; default: audio_seq_end = 1;
      endcase
      tick();
      start_btn = 0; continue_btn = 0; pause_btn = 0;
      player_dead = 0; level_complete = 0; audio_seq_end = 0;
   endtask

   task automatic waitPlay();
      int k = 0;
      while (!(screen === 3'd1 && player_disable === 1'b0) && k < 60) begin
         tick();
         k++;
      end
      if (k >= 60) chk("wait_play_timeout", {28'd0, screen, player_disable}, 32'd2);
   endtask

   initial begin
      int n;
      start_btn = 1;
      rst = 1;
      #23 rst = 0;
      tick();
      chk("rst_screen", 32'(screen), 0);
      chk("rst_lives", 32'(lives), 3);
      chk("rst_led", 32'(lives_led), 7);
      chk("rst_disable", 32'(player_disable), 1);
      chk("rst_audio_en", 32'(audio_enable), 0);
      tick(); tick();
      chk("held_start_no_arm", 32'(reset_select), 0);
      start_btn = 0;
      tick();
      sigPulse(0);
      chk("arm_entry", 32'(reset_select), 1);
      chk("arm_screen", 32'(screen), 0);
      n = 1;
      while (n < 20) begin
         tick();
         if (reset_select !== 1'b1) break;
         n++;
      end
      chk("arm_len", n, 4);
      chk("play_screen", 32'(screen), 1);
      chk("play_disable", 32'(player_disable), 0);
      chk("play_led", 32'(lives_led), 7);

      sigPulse(4);
      chk("lvlup1_level", 32'(level), 1);
      chk("lvlup1_screen", 32'(screen), 4);
      sigPulse(1); waitPlay();
      sigPulse(4);
      chk("lvlup2_level", 32'(level), 2);
      sigPulse(1); waitPlay();
      sigPulse(4);
      chk("wup_world", 32'(world), 1);
      chk("wup_level", 32'(level), 0);
      chk("wup_screen", 32'(screen), 5);
      sigPulse(1); waitPlay();

      player_dead = 1; level_complete = 1;
      tick();
      player_dead = 0; level_complete = 0;
      chk("both_screen", 32'(screen), 7);
      chk("both_lives", 32'(lives), 2);
      chk("both_level", 32'(level), 0);
      chk("both_led", 32'(lives_led), 3);
      sigPulse(1); waitPlay();
      sigPulse(3);
      chk("died2_lives", 32'(lives), 1);
      chk("died2_led", 32'(lives_led), 1);
      sigPulse(1); waitPlay();
      sigPulse(3);
      chk("go_lives", 32'(lives), 0);
      chk("go_screen", 32'(screen), 2);
      chk("go_audio", 32'(audio_select), 5);
      sigPulse(1);
      chk("go_to_idle", 32'(screen), 0);

      tick();
      sigPulse(0); waitPlay();
      chk("restart_lives", 32'(lives), 3);
      sigPulse(2);
      chk("pause_screen", 32'(screen), 6);
      chk("pause_audio", 32'(audio_enable), 0);
      sigPulse(3);
      chk("pause_dead_ignored", 32'(lives), 3);
      sigPulse(2);
      chk("resume_screen", 32'(screen), 1);
      chk("resume_no_arm", 32'(reset_select), 0);

      sigPulse(4);
      chk("hold_entry_audio", 32'(audio_enable), 1);
      n = 0;
      tick(); n++;
      tick(); n++;
      audio_seq_end = 1;
      tick(); n++;
      audio_seq_end = 0;
      chk("seq_end_audio_off", 32'(audio_enable), 0);
      while (reset_select !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk("hold_len", n, 10);
      chk("hold_arm_screen", 32'(screen), 4);
      tick();
      #2 rst = 1;
      #1;
      chk("async_rst_screen", 32'(screen), 0);
      chk("async_rst_level", 32'(level), 0);
      chk("async_rst_rs", 32'(reset_select), 0);
      chk("async_rst_disable", 32'(player_disable), 1);
      chk("async_rst_lives", 32'(lives), 3);
      @(negedge clk) rst = 0;
      tick();

      tick();
      sigPulse(0); waitPlay();
      for (int i = 0; i < NW * LPW; i++) begin
         sigPulse(4);
         if (i < NW * LPW - 1) begin
            sigPulse(1); waitPlay();
         end
      end
      chk("win_screen", 32'(screen), 3);
      chk("win_audio", 32'(audio_select), 6);
      chk("win_world", 32'(world), 3);
      sigPulse(0);
      chk("win_to_idle", 32'(screen), 0);
      chk("idle_keeps_level", 32'(level), 2);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
         if ($urandom_range(0, 5) == 0) continue_btn = ~continue_btn;
         if ($urandom_range(0, 11) == 0) pause_btn = ~pause_btn;
         player_dead    = ($urandom_range(0, 39) == 0);
         level_complete = ($urandom_range(0, 24) == 0);
         audio_seq_end  = ($urandom_range(0, 5) == 0);
         rst            = ($urandom_range(0, 799) == 0);
         tick();
      end
      rst = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
